// File: rtl/axil_user_reg_bank_pkg.sv
// Shared constants and state encodings for the AXI4-Lite user register bank.
//   RESP_*      : AXI response codes returned on BRESP / RRESP
//   wr_state_e  : write-channel FSM states
//   rd_state_e  : read-channel FSM states
package axil_user_reg_bank_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_AW,
        W_HAVE_W,
        W_RESP
    } wr_state_e;

    typedef enum logic {
        R_IDLE,
        R_VALID
    } rd_state_e;

endpackage

// File: rtl/axil_user_reg_bank.sv
// AXI4-Lite slave exposing NUM_REGS user registers of DATA_WIDTH bits.
// Writable registers are byte-enabled and reset to RESET_VAL; registers whose
// RO_MASK bit is set read back the matching reg_in slice instead.
//
// Ports:
//   S_AXI_ACLK / S_AXI_ARESET : clock, synchronous active-high reset
//   S_AXI_AW* / S_AXI_W* / S_AXI_B* : write address, data and response channels
//   S_AXI_AR* / S_AXI_R*             : read address and data channels
//   reg_out  : flat register contents, register i at slice i (RO slices are 0)
//   reg_in   : flat read-only sources, register i at slice i
//   wr_pulse : one-cycle strobe per register when a legal write commits
//
// Write FSM
//   state     | meaning
//   W_IDLE    | waiting; AW and W both accepted, together or separately
//   W_HAVE_AW | address latched, waiting for data
//   W_HAVE_W  | data latched, waiting for address
//   W_RESP    | first cycle commits the write; BVALID held until BREADY
//
// Read FSM
//   state     | meaning
//   R_IDLE    | ARREADY high, waiting for an address
//   R_VALID   | RDATA/RRESP held until RREADY
module axil_user_reg_bank
    import axil_user_reg_bank_pkg::*;
#(
    parameter int                    NUM_REGS   = 8,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [NUM_REGS-1:0]   RO_MASK    = '0,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0,
    localparam int ADDR_WIDTH = $clog2(NUM_REGS) + $clog2(DATA_WIDTH/8) + 1
) (
    input  logic                           S_AXI_ACLK,
    input  logic                           S_AXI_ARESET,

    input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic [2:0]                     S_AXI_AWPROT,
    input  logic                           S_AXI_AWVALID,
    output logic                           S_AXI_AWREADY,

    input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
    input  logic                           S_AXI_WVALID,
    output logic                           S_AXI_WREADY,

    output logic [1:0]                     S_AXI_BRESP,
    output logic                           S_AXI_BVALID,
    input  logic                           S_AXI_BREADY,

    input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic [2:0]                     S_AXI_ARPROT,
    input  logic                           S_AXI_ARVALID,
    output logic                           S_AXI_ARREADY,

    output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                     S_AXI_RRESP,
    output logic                           S_AXI_RVALID,
    input  logic                           S_AXI_RREADY,

    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_in,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(NUM_REGS);

    // Index and out-of-range flag decoded straight from the bus addresses.
    logic [IDX_W-1:0] awaddr_idx;
    logic             awaddr_oob;
    logic [IDX_W-1:0] araddr_idx;
    logic             araddr_oob;

    assign awaddr_idx = S_AXI_AWADDR[ADDR_WIDTH-2:OFF_W];
    assign awaddr_oob = S_AXI_AWADDR[ADDR_WIDTH-1];
    assign araddr_idx = S_AXI_ARADDR[ADDR_WIDTH-2:OFF_W];
    assign araddr_oob = S_AXI_ARADDR[ADDR_WIDTH-1];

    // Protection bits, byte offsets and the reg_in slices of writable
    // registers carry no meaning for this block.
    logic unused_inputs;
    assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                             S_AXI_AWADDR[OFF_W-1:0], S_AXI_ARADDR[OFF_W-1:0],
                             reg_in};

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    wr_state_e          w_state_q, w_state_d;
    logic [IDX_W-1:0]   aw_idx_q, aw_idx_d;
    logic               aw_oob_q, aw_oob_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0]  wstrb_q, wstrb_d;
    logic               commit_q, commit_d;
    logic               awready, wready, bvalid;
    logic [1:0]         bresp;
    logic               wr_legal;

    always_comb begin
        w_state_d = w_state_q;
        aw_idx_d  = aw_idx_q;
        aw_oob_d  = aw_oob_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        commit_d  = 1'b0;
        awready   = 1'b0;
        wready    = 1'b0;
        bvalid    = 1'b0;
        bresp     = RESP_OKAY;

        case (w_state_q)
            W_IDLE: begin
                awready = 1'b1;
                wready  = 1'b1;
                if (S_AXI_AWVALID) begin
                    aw_idx_d = awaddr_idx;
                    aw_oob_d = awaddr_oob;
                end
                if (S_AXI_WVALID) begin
                    wdata_d = S_AXI_WDATA;
                    wstrb_d = S_AXI_WSTRB;
                end
                if (S_AXI_AWVALID && S_AXI_WVALID) begin
                    w_state_d = W_RESP;
                    commit_d  = 1'b1;
                end else if (S_AXI_AWVALID) begin
                    w_state_d = W_HAVE_AW;
                end else if (S_AXI_WVALID) begin
                    w_state_d = W_HAVE_W;
                end
            end
            W_HAVE_AW: begin
                wready = 1'b1;
                if (S_AXI_WVALID) begin
                    wdata_d   = S_AXI_WDATA;
                    wstrb_d   = S_AXI_WSTRB;
                    w_state_d = W_RESP;
                    commit_d  = 1'b1;
                end
            end
            W_HAVE_W: begin
                awready = 1'b1;
                if (S_AXI_AWVALID) begin
                    aw_idx_d  = awaddr_idx;
                    aw_oob_d  = awaddr_oob;
                    w_state_d = W_RESP;
                    commit_d  = 1'b1;
                end
            end
            W_RESP: begin
                bvalid = 1'b1;
                // Derived from latched address only, so it stays stable
                // for as long as BVALID is held.
                if (aw_oob_q) begin
                    bresp = RESP_DECERR;
                end else if (RO_MASK[aw_idx_q]) begin
                    bresp = RESP_SLVERR;
                end
                if (S_AXI_BREADY) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            w_state_q <= W_IDLE;
            aw_idx_q  <= '0;
            aw_oob_q  <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            commit_q  <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            aw_idx_q  <= aw_idx_d;
            aw_oob_q  <= aw_oob_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            commit_q  <= commit_d;
        end
    end

    // commit_q marks the first W_RESP cycle; registers update at its end so a
    // read accepted in that same cycle still sees the old contents.
    assign wr_legal = commit_q && !aw_oob_q && !RO_MASK[aw_idx_q];

    assign S_AXI_AWREADY = awready;
    assign S_AXI_WREADY  = wready;
    assign S_AXI_BVALID  = bvalid;
    assign S_AXI_BRESP   = bresp;

    // ------------------------------------------------------------------
    // Register storage
    // ------------------------------------------------------------------
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] reg_view;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        assign wr_pulse[i] = wr_legal && (aw_idx_q == IDX_W'(i));

        if (RO_MASK[i]) begin : g_ro
            assign reg_view[i] = reg_in[i*DATA_WIDTH +: DATA_WIDTH];
            assign reg_out[i*DATA_WIDTH +: DATA_WIDTH] = '0;
        end else begin : g_rw
            logic [DATA_WIDTH-1:0] val_q;

            always_ff @(posedge S_AXI_ACLK) begin
                if (S_AXI_ARESET) begin
                    val_q <= RESET_VAL;
                end else if (wr_pulse[i]) begin
                    for (int b = 0; b < STRB_W; b++) begin
                        if (wstrb_q[b]) begin
                            val_q[b*8 +: 8] <= wdata_q[b*8 +: 8];
                        end
                    end
                end
            end

            assign reg_view[i] = val_q;
            assign reg_out[i*DATA_WIDTH +: DATA_WIDTH] = val_q;
        end
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    rd_state_e             r_state_q, r_state_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic                  arready, rvalid;

    always_comb begin
        r_state_d = r_state_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        arready   = 1'b0;
        rvalid    = 1'b0;

        case (r_state_q)
            R_IDLE: begin
                arready = 1'b1;
                if (S_AXI_ARVALID) begin
                    r_state_d = R_VALID;
                    if (araddr_oob) begin
                        rdata_d = '0;
                        rresp_d = RESP_DECERR;
                    end else begin
                        rdata_d = reg_view[araddr_idx];
                        rresp_d = RESP_OKAY;
                    end
                end
            end
            R_VALID: begin
                rvalid = 1'b1;
                if (S_AXI_RREADY) begin
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_state_q <= R_IDLE;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            r_state_q <= r_state_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    assign S_AXI_ARREADY = arready;
    assign S_AXI_RVALID  = rvalid;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;

endmodule

// File: tb/tb_axil_user_reg_bank.sv
// Scoreboard bench for axil_user_reg_bank: stimulus pushes expected B/R
// responses and wr_pulse vectors into queues; a negedge monitor pops and
// compares whenever the DUT presents them.
module tb_axil_user_reg_bank;

    localparam int NR = 8;
    localparam int DW = 32;
    localparam int AW = 6;
    localparam logic [31:0] RV = 32'hA5A5_5A5A;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [AW-1:0]   awaddr = '0;
    logic [2:0]      awprot = '0;
    logic            awvalid = 1'b0;
    logic            awready;
    logic [DW-1:0]   wdata = '0;
    logic [3:0]      wstrb = '0;
    logic            wvalid = 1'b0;
    logic            wready;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready = 1'b1;
    logic [AW-1:0]   araddr = '0;
    logic [2:0]      arprot = '0;
    logic            arvalid = 1'b0;
    logic            arready;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;
    logic            rvalid;
    logic            rready = 1'b1;
    logic [NR*DW-1:0] reg_out;
    logic [NR*DW-1:0] reg_in;
    logic [NR-1:0]   wr_pulse;

    axil_user_reg_bank #(
        .NUM_REGS  (NR),
        .DATA_WIDTH(DW),
        .RO_MASK   (8'h01),
        .RESET_VAL (RV)
    ) dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESET (rst),
        .S_AXI_AWADDR (awaddr),
        .S_AXI_AWPROT (awprot),
        .S_AXI_AWVALID(awvalid),
        .S_AXI_AWREADY(awready),
        .S_AXI_WDATA  (wdata),
        .S_AXI_WSTRB  (wstrb),
        .S_AXI_WVALID (wvalid),
        .S_AXI_WREADY (wready),
        .S_AXI_BRESP  (bresp),
        .S_AXI_BVALID (bvalid),
        .S_AXI_BREADY (bready),
        .S_AXI_ARADDR (araddr),
        .S_AXI_ARPROT (arprot),
        .S_AXI_ARVALID(arvalid),
        .S_AXI_ARREADY(arready),
        .S_AXI_RDATA  (rdata),
        .S_AXI_RRESP  (rresp),
        .S_AXI_RVALID (rvalid),
        .S_AXI_RREADY (rready),
        .reg_out      (reg_out),
        .reg_in       (reg_in),
        .wr_pulse     (wr_pulse)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] d;
        logic [1:0]  r;
    } rexp_t;

    logic [1:0]  bq[$];
    rexp_t       rq[$];
    logic [7:0]  pq[$];
    logic [31:0] mdl [NR];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: compare whenever the DUT presents a response or a pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (bvalid && bready) begin
                if (bq.size() == 0) chk("b_unexpected", 64'(bvalid), 64'd0);
                else                chk("bresp", 64'(bresp), 64'(bq.pop_front()));
            end
            if (rvalid && rready) begin
                if (rq.size() == 0) begin
                    chk("r_unexpected", 64'(rvalid), 64'd0);
                end else begin
                    rexp_t e;
                    e = rq.pop_front();
                    chk("rdata", 64'(rdata), 64'(e.d));
                    chk("rresp", 64'(rresp), 64'(e.r));
                end
            end
            if (wr_pulse != '0) begin
                if (pq.size() == 0) chk("pulse_unexpected", 64'(wr_pulse), 64'd0);
                else                chk("wr_pulse", 64'(wr_pulse), 64'(pq.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) mdl[i] = RV;
    endtask

    task automatic write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                         input logic [1:0] er, input logic [7:0] ep);
        logic aw_done, w_done, aw_hs, w_hs;
        bq.push_back(er);
        if (ep != 0) begin
            pq.push_back(ep);
            for (int b = 0; b < 4; b++)
                if (s[b]) mdl[a[4:2]][b*8 +: 8] = d[b*8 +: 8];
        end
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        aw_done = 1'b0; w_done = 1'b0;
        for (int n = 0; n < 20 && !(aw_done && w_done); n++) begin
            @(negedge clk);
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            tick();
            if (aw_hs) begin awvalid = 1'b0; aw_done = 1'b1; end
            if (w_hs)  begin wvalid  = 1'b0; w_done  = 1'b1; end
        end
        if (!(aw_done && w_done)) chk("write_handshake", {62'd0, aw_done, w_done}, 64'd3);
    endtask

    task automatic read(input logic [AW-1:0] a, input logic [31:0] ed, input logic [1:0] er);
        logic done, hs;
        rexp_t e;
        e.d = ed; e.r = er;
        rq.push_back(e);
        araddr = a; arvalid = 1'b1; done = 1'b0;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            hs = arvalid && arready;
            tick();
            if (hs) begin arvalid = 1'b0; done = 1'b1; end
        end
        if (!done) chk("read_handshake", 64'(done), 64'd1);
    endtask

    task automatic drain();
        for (int n = 0; n < 60; n++) begin
            if (bq.size() == 0 && rq.size() == 0 && pq.size() == 0) break;
            tick();
        end
        chk("drain_pending", 64'(bq.size() + rq.size() + pq.size()), 64'd0);
    endtask

    task automatic check_regs();
        @(negedge clk);
        for (int i = 0; i < NR; i++)
            chk($sformatf("reg_out%0d", i), 64'(reg_out[i*DW +: DW]), (i == 0) ? 64'd0 : 64'(mdl[i]));
        tick();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < NR; i++) reg_in[i*DW +: DW] = 32'hDEAD_0000 + 32'(i);
        reg_in[31:0] = 32'h1357_2468;
        model_reset();

        // Reset state
        tick(); tick();
        @(negedge clk);
        chk("rst_awready", 64'(awready), 64'd1);
        chk("rst_wready",  64'(wready),  64'd1);
        chk("rst_arready", 64'(arready), 64'd1);
        chk("rst_bvalid",  64'(bvalid),  64'd0);
        chk("rst_rvalid",  64'(rvalid),  64'd0);
        chk("rst_bresp",   64'(bresp),   64'd0);
        chk("rst_rresp",   64'(rresp),   64'd0);
        chk("rst_rdata",   64'(rdata),   64'd0);
        chk("rst_pulse",   64'(wr_pulse), 64'd0);
        tick();
        rst = 1'b0;
        check_regs();

        // Full write to reg 2, read back, read with ignored byte offset
        write(6'h08, 32'h1122_3344, 4'hF, 2'b00, 8'h04);
        drain();
        read(6'h08, 32'h1122_3344, 2'b00);
        read(6'h0B, 32'h1122_3344, 2'b00);
        drain();

        // AW at cycle 0, W at cycle 3, BVALID at cycle 4
        write(6'h04, 32'h0000_0000, 4'hF, 2'b00, 8'h02);
        drain();
        bq.push_back(2'b00);
        pq.push_back(8'h02);
        mdl[1] = 32'h0000_CCDD;
        awaddr = 6'h04; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        @(negedge clk);
        chk("have_aw_awready", 64'(awready), 64'd0);
        chk("have_aw_wready",  64'(wready),  64'd1);
        tick();
        tick();
        wdata = 32'hAABB_CCDD; wstrb = 4'h3; wvalid = 1'b1;
        @(negedge clk);
        chk("split_bvalid_c3", 64'(bvalid), 64'd0);
        tick();
        wvalid = 1'b0;
        @(negedge clk);
        chk("split_bvalid_c4", 64'(bvalid), 64'd1);
        drain();
        read(6'h04, 32'h0000_CCDD, 2'b00);
        drain();

        // Partial strobes and an all-zero strobe
        write(6'h0C, 32'hDEAD_BEEF, 4'hF, 2'b00, 8'h08);
        write(6'h0C, 32'h0099_0000, 4'h4, 2'b00, 8'h08);
        write(6'h0C, 32'h1111_1111, 4'h0, 2'b00, 8'h08);
        drain();
        read(6'h0C, 32'hDE99_BEEF, 2'b00);
        drain();

        // Read-only register 0
        reg_in[31:0] = 32'hCAFE_F00D;
        write(6'h00, 32'h1234_5678, 4'hF, 2'b10, 8'h00);
        drain();
        read(6'h00, 32'hCAFE_F00D, 2'b00);
        drain();

        // Out-of-range window
        write(6'h20, 32'hFFFF_FFFF, 4'hF, 2'b11, 8'h00);
        drain();
        read(6'h20, 32'h0000_0000, 2'b11);
        read(6'h2C, 32'h0000_0000, 2'b11);
        drain();
        check_regs();

        // BREADY held low: response and ready stable
        bready = 1'b0;
        write(6'h10, 32'h0102_0304, 4'hF, 2'b00, 8'h10);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bhold_bvalid",  64'(bvalid),  64'd1);
            chk("bhold_bresp",   64'(bresp),   64'd0);
            chk("bhold_awready", 64'(awready), 64'd0);
            chk("bhold_wready",  64'(wready),  64'd0);
            tick();
        end
        bready = 1'b1;
        drain();

        // RREADY held low
        rready = 1'b0;
        read(6'h10, 32'h0102_0304, 2'b00);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("rhold_rvalid",  64'(rvalid),  64'd1);
            chk("rhold_rdata",   64'(rdata),   64'h0102_0304);
            chk("rhold_rresp",   64'(rresp),   64'd0);
            chk("rhold_arready", 64'(arready), 64'd0);
            tick();
        end
        rready = 1'b1;
        drain();

        // Reset in W_HAVE_AW discards the latched address
        awaddr = 6'h14; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        @(negedge clk);
        chk("pre_rst_awready", 64'(awready), 64'd0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        chk("post_rst_bvalid",  64'(bvalid),  64'd0);
        chk("post_rst_awready", 64'(awready), 64'd1);
        chk("post_rst_wready",  64'(wready),  64'd1);
        tick();
        wdata = 32'h7777_8888; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("w_only_bvalid", 64'(bvalid), 64'd0);
            tick();
        end
        bq.push_back(2'b00);
        pq.push_back(8'h40);
        mdl[6] = 32'h7777_8888;
        awaddr = 6'h18; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        drain();
        check_regs();

        // Back-to-back writes plus a read landing in the commit cycle
        bq.push_back(2'b00); bq.push_back(2'b00);
        pq.push_back(8'h80); pq.push_back(8'h80);
        awaddr = 6'h1C; wdata = 32'h0BAD_0001; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        chk("b2b_ready_c0", 64'(awready), 64'd1);
        tick();
        wdata = 32'h0BAD_0002;
        begin
            rexp_t e;
            e.d = RV; e.r = 2'b00;
            rq.push_back(e);
        end
        araddr = 6'h1C; arvalid = 1'b1;
        @(negedge clk);
        chk("b2b_ready_c1", 64'(awready), 64'd0);
        chk("b2b_arready_c1", 64'(arready), 64'd1);
        tick();
        arvalid = 1'b0;
        @(negedge clk);
        chk("b2b_ready_c2", 64'(awready), 64'd1);
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        mdl[7] = 32'h0BAD_0002;
        drain();
        read(6'h1C, 32'h0BAD_0002, 2'b00);
        drain();
        check_regs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
